// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - two-digit BCD countdown timer with prescaler; option macro COUNTDOWN_AUTO_RELOAD_EN
module countdown_timer_ctrl #(
  parameter int TICK_PERIOD = 5000000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] LED,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int            PW         = $clog2(TICK_PERIOD);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_PERIOD - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    count_q, count_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic          do_load;
  logic [7:0]    load_val;
  logic [7:0]    dec_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Clamped preset captured at load so later reloads never resample the input pins.
  logic [7:0]    reload_q, reload_d;
`endif

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Next-state and next-output logic; clear is applied last so it wins over everything.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_d  = count_q;
    done_d   = 1'b0;
    do_load  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
    load_val = {clamp9(preset[7:4]), clamp9(preset[3:0])};
    dec_val  = (count_q[3:0] != 4'd0) ? {count_q[7:4], count_q[3:0] - 4'd1}
                                      : {count_q[7:4] - 4'd1, 4'd9};

    case (state_q)
      IDLE: begin
        presc_d = '0;
        do_load = start;
      end
      RUN: begin
        if (tick) begin
          presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          // At 00 the next tick reloads instead of borrowing below zero.
          if (count_q == 8'h00) begin
            count_d = reload_q;
          end else begin
            count_d = dec_val;
            done_d  = (dec_val == 8'h00);
          end
          if (pause) state_d = PAUSE;
`else
          count_d = dec_val;
          if (dec_val == 8'h00) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (pause) begin
            state_d = PAUSE;
          end
`endif
        end else begin
          presc_d = presc_q + PW'(1);
          if (pause) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start || pause) state_d = RUN;
      end
      DONE: begin
        presc_d = '0;
        do_load = start;
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      count_d = load_val;
      presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      if (load_val == 8'h00) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    if (clear) begin
      state_d = IDLE;
      count_d = 8'h00;
      presc_d = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d == RUN);
  end

  // State, counters and all outputs registered; reset overrides every command.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      count_q  <= 8'h00;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign LED   = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - scoreboard bench for countdown_timer_ctrl at TICK_PERIOD=4
module tb_countdown_timer_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic       clk;
  logic       rst;
  logic [7:0] preset;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] led;
  logic       busy;
  logic       done;
  logic [1:0] state;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       done;
    logic [1:0] st;
  } exp_t;

  exp_t       sb[$];
  int         cyc;
  int         checks;
  int         failures;
  logic       mon_en;
  logic [7:0] prev_led;
  logic [1:0] prev_st;
  int         c0;

  countdown_timer_ctrl #(.TICK_PERIOD(4)) dut (
    .CLK_50M (clk),
    .RST     (rst),
    .preset  (preset),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .LED     (led),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp_v);
    end
  endtask

  function automatic void push(input int c, input logic [7:0] l, input logic d, input logic [1:0] s);
    exp_t e;
    e.cyc  = c;
    e.led  = l;
    e.done = d;
    e.st   = s;
    sb.push_back(e);
  endfunction

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s;
    pause = p;
    clear = c;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: any change of LED or state, or any done-high cycle, is an output event to score.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (led !== prev_led || state !== prev_st || done !== 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event cyc=%0d LED=%h state=%0d done=%b", cyc, led, state, done);
        end else begin
          e = sb.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("event_led", 32'(led), 32'(e.led));
          chk("event_done", 32'(done), 32'(e.done));
          chk("event_state", 32'(state), 32'(e.st));
          chk("event_busy", 32'(busy), 32'(e.st == S_RUN));
        end
      end
    end
    prev_led = led;
    prev_st  = state;
  end

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    preset   = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_led", 32'(led), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    c0 = cyc;
    push(c0 + 1,  8'h02, 1'b0, S_RUN);
    push(c0 + 5,  8'h01, 1'b0, S_RUN);
    push(c0 + 9,  8'h00, 1'b1, S_RUN);
    push(c0 + 13, 8'h02, 1'b0, S_RUN);
    push(c0 + 17, 8'h01, 1'b0, S_RUN);
    push(c0 + 21, 8'h00, 1'b1, S_RUN);
    push(c0 + 23, 8'h00, 1'b0, S_IDLE);
    preset = 8'h02;
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 22);
    pulse(1'b0, 1'b0, 1'b1);
    c0 = cyc;
    push(c0 + 1, 8'h00, 1'b1, S_DONE);
    preset = 8'h00;
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 5);
`else
    // Basic countdown 12 -> 00, one step every 4 cycles.
    c0 = cyc;
    push(c0 + 1, 8'h12, 1'b0, S_RUN);
    for (int k = 1; k <= 12; k++)
      push(c0 + 1 + 4 * k, bcd(12 - k), (k == 12), (k == 12) ? S_DONE : S_RUN);
    preset = 8'h12;
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 52);

    // Clamp 3F -> 39 from DONE, then clear.
    c0 = cyc;
    push(c0 + 1, 8'h39, 1'b0, S_RUN);
    push(c0 + 2, 8'h00, 1'b0, S_IDLE);
    preset = 8'h3F;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);

    // Borrow 20 -> 19 -> 18, then clear+start in RUN and again in IDLE.
    c0 = cyc;
    push(c0 + 1,  8'h20, 1'b0, S_RUN);
    push(c0 + 5,  8'h19, 1'b0, S_RUN);
    push(c0 + 9,  8'h18, 1'b0, S_RUN);
    push(c0 + 11, 8'h00, 1'b0, S_IDLE);
    preset = 8'h20;
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 10);
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    wait_cyc(c0 + 14);

    // Pause two cycles after a tick, hold, resume, then pause on the final tick.
    c0 = cyc;
    push(c0 + 1,  8'h05, 1'b0, S_RUN);
    push(c0 + 5,  8'h04, 1'b0, S_RUN);
    push(c0 + 7,  8'h04, 1'b0, S_PAUSE);
    push(c0 + 17, 8'h04, 1'b0, S_RUN);
    push(c0 + 19, 8'h03, 1'b0, S_RUN);
    push(c0 + 23, 8'h02, 1'b0, S_RUN);
    push(c0 + 27, 8'h01, 1'b0, S_RUN);
    push(c0 + 31, 8'h00, 1'b1, S_DONE);
    preset = 8'h05;
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 6);
    pulse(1'b1, 1'b1, 1'b0);
    wait_cyc(c0 + 16);
    pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(c0 + 21);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 30);
    pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(c0 + 32);
    pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(c0 + 35);

    // Reset mid-run at 07 with start held, then preset 00 right after reset.
    c0 = cyc;
    push(c0 + 1,  8'h09, 1'b0, S_RUN);
    push(c0 + 5,  8'h08, 1'b0, S_RUN);
    push(c0 + 9,  8'h07, 1'b0, S_RUN);
    push(c0 + 11, 8'h00, 1'b0, S_IDLE);
    push(c0 + 12, 8'h00, 1'b1, S_DONE);
    preset = 8'h09;
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 10);
    rst    = 1'b1;
    start  = 1'b1;
    preset = 8'h00;
    @(negedge clk);
    rst    = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    wait_cyc(c0 + 16);

    // Clear out of DONE.
    c0 = cyc;
    push(c0 + 1, 8'h00, 1'b0, S_IDLE);
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(c0 + 5);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("  pending event cyc=%0d LED=%h done=%b state=%0d", e.cyc, e.led, e.done, e.st);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 Parameter TICK_PERIOD, default 5000000, CLK_50M cycles per count step (10 Hz at 50 MHz); legal range 2..2^30-1.
REQ-002 CLK_50M  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 preset  input  8  BCD start value {tens[7:4], units[3:0]}, sampled only at load.
REQ-005 start  input  1  single-cycle command pulse: load and run, or resume.
REQ-006 pause  input  1  single-cycle command pulse: suspend counting.
REQ-007 clear  input  1  single-cycle command pulse: abort to IDLE.
REQ-008 LED  output  8  current BCD count {tens, units}.
REQ-009 busy  output  1  high exactly while state is RUN.
REQ-010 done  output  1  one-cycle pulse when the count reaches 00.
REQ-011 state  output  2  encoded FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-012 The block SHALL contain a prescaler counting 0..TICK_PERIOD-1 and a two-digit BCD down counter clocked by CLK_50M, with no derived clocks.
REQ-013 The prescaler SHALL advance only in RUN, hold its value in PAUSE, and be forced to 0 in IDLE, in DONE, and on every load.
REQ-014 An internal tick SHALL assert for one cycle when the prescaler equals TICK_PERIOD-1 in RUN, and the prescaler SHALL return to 0 on that cycle.
REQ-015 The first tick after a load SHALL occur exactly TICK_PERIOD cycles after the start pulse.
REQ-016 On load, each preset nibble greater than 9 SHALL be clamped to 9 before being written to the count.
REQ-017 On each tick: if units>0, units SHALL decrement; otherwise units SHALL become 9 and tens SHALL decrement.
REQ-018 IDLE + start SHALL load preset and enter RUN. If the clamped preset is 00, the block SHALL instead enter DONE and pulse done on the next cycle.
REQ-019 RUN + pause SHALL enter PAUSE; a start pulse in the same cycle SHALL be ignored.
REQ-020 PAUSE + start or pause SHALL return to RUN without reloading; the count and prescaler SHALL continue from their held values.
REQ-021 A tick that produces 00 SHALL raise done for exactly one cycle, registered and coincident with LED showing 00.
REQ-022 That 00 tick SHALL move the FSM to DONE, except where REQ-031 applies.
REQ-023 DONE + start SHALL reload preset and enter RUN, with the same behaviour as REQ-018.
REQ-024 clear in any state SHALL enter IDLE and set LED to 00 on the next cycle; clear has priority over start, pause and tick in the same cycle.
REQ-025 If pause and tick coincide in RUN, the decrement SHALL be applied first and the FSM SHALL then enter PAUSE, or DONE if the count reached 00.
REQ-026 Commands not listed for the current state SHALL be ignored.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While RST is high at a clock edge, the outputs SHALL take: state=IDLE, LED=00, busy=0, done=0, prescaler=0.
REQ-029 RST SHALL override clear, start, pause and tick, including a reset asserted mid-RUN or mid-PAUSE.
REQ-030 In the first cycle after RST deasserts, the block SHALL accept commands.

Configuration
REQ-031 With macro COUNTDOWN_AUTO_RELOAD_EN defined, a tick producing 00 in RUN SHALL pulse done, reload the clamped preset on the next tick instead of entering DONE, and stay in RUN (sequence …, 01, 00, preset, …).
REQ-032 With COUNTDOWN_AUTO_RELOAD_EN undefined, the block SHALL enter DONE at 00 and hold LED=00 until start, clear or RST.
REQ-033 With COUNTDOWN_AUTO_RELOAD_EN defined, a clamped preset of 00 SHALL still enter DONE per REQ-018.

Verification (TICK_PERIOD=4 unless noted)
REQ-034 Bench SHALL cover basic countdown: preset=8'h12, start pulse -> LED steps 12,11,10,09,…,00 every 4 cycles; done high exactly one cycle, coincident with LED=00; state=DONE; busy=0.
REQ-035 Bench SHALL cover BCD borrow and clamp: preset=8'h3F -> loads 39; preset=8'h20 -> step sequence 20,19,18.
REQ-036 Bench SHALL cover pause/resume: pause 2 cycles after a tick, hold 10 cycles -> LED and state frozen; after resume the next tick arrives exactly 2 cycles later.
REQ-037 Bench SHALL cover collisions: clear+start in the same cycle -> IDLE, LED=00; pause coincident with a tick at LED=01 -> LED=00, done pulse, state=DONE.
REQ-038 Bench SHALL cover reset: RST mid-RUN at LED=07 -> next cycle LED=00, state=IDLE, done=0; preset=00 with start -> DONE with a single done pulse.
REQ-039 Bench SHALL cover auto-reload with COUNTDOWN_AUTO_RELOAD_EN defined and preset=8'h02 -> LED 02,01,00,02,01,00; done pulses at each 00; busy held at 1.
